// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//
// Time-multiplexed scan controller for NUM_DIGITS common-anode seven-segment
// digits sharing one external combinational hex decoder. A committed display
// word (disp) is scanned one nibble per slot; a shadow word collects new
// values, which are only transferred to disp at a frame boundary so the
// visible pattern never tears mid-frame.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   -> digit k>0 stays dark when nibble k and every higher nibble
//                of disp are zero (digit 0 always lit)
//   undefined -> every digit is lit in its slot outside the guard window
//
// Ports
//   clk      in   single clock, all state on rising edge
//   rst      in   synchronous active-high reset
//   value    in   display word, nibble k -> digit k (digit 0 rightmost)
//   load     in   one-cycle strobe capturing value into the shadow
//   pending  out  shadow holds a value not yet committed
//   commit   out  one-cycle pulse the cycle after a commit
//   hex      out  nibble of the current digit, to the shared decoder
//   seg_in   in   decoder result for hex, {g..a}, active-high
//   seg      out  registered segment drive, active-high
//   an       out  registered anode enables, active-low

module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  output logic                    pending,
  output logic                    commit,
  output logic [3:0]              hex,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic                    commit_q, commit_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    frame_end;
  logic                    in_guard;
  logic [NUM_DIGITS-1:0]   digit_lit;

  // Dead-time window at the start of each slot; a zero guard removes the
  // compare entirely rather than testing against a constant zero.
  if (GUARD_CYCLES == 0) begin : g_no_guard
    assign in_guard = 1'b0;
  end else begin : g_guard
    localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_CYCLES);
    assign in_guard = (div_cnt_q < GUARD_LIM);
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the most significant nibble down: once any nonzero nibble has
  // been seen, that digit and every lower one are lit.
  always_comb begin : blank_mask
    logic seen_nz;
    seen_nz   = 1'b0;
    digit_lit = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      seen_nz      = seen_nz | (disp_q[4*k +: 4] != 4'h0);
      digit_lit[k] = seen_nz || (k == 0);
    end
  end
`else
  assign digit_lit = '1;
`endif

  assign frame_end = (div_cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

  // Current nibble for the shared decoder, straight from registers.
  always_comb begin
    hex = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) hex = disp_q[4*k +: 4];
    end
  end

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (div_cnt_q == CNT_LAST) begin
      div_cnt_d = '0;
      idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    commit_d  = 1'b0;

    // A load landing on the boundary bypasses the shadow, so the stale
    // shadow content is never shown.
    if (frame_end && load) begin
      disp_d    = value;
      shadow_d  = value;
      pending_d = 1'b0;
      commit_d  = 1'b1;
    end else if (frame_end && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
      commit_d  = 1'b1;
    end else if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end

    // seg and an are registered together from the same idx so the lit
    // digit always carries its own pattern.
    seg_d = seg_in;
    an_d  = '1;
    if (!in_guard) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if ((idx_q == IDX_W'(k)) && digit_lit[k]) an_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      commit_q  <= 1'b0;
      seg_q     <= '0;
      an_q      <= '1;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      commit_q  <= commit_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign pending = pending_q;
  assign commit  = commit_q;
  assign seg     = seg_q;
  assign an      = an_q;

endmodule
